// File: rtl/uart_rx_ctrl.sv
// UART receive front-end: oversamples RX_IN, 2-of-3 votes each bit and sequences the frame.
// Optional macro RX_SYNC_EN inserts a 2-flop input synchronizer (frame timing shifts 2 cycles).

module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  sampled_bit,
    output logic                  deser_en,
    output logic                  new_op_flag,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_r;
    logic [PRESCALE_W-1:0] prescale_r;
    logic [PRESCALE_W-1:0] edge_cnt_r;
    logic [BCW-1:0]        bit_cnt_r;
    logic                  samp0_r;
    logic                  samp1_r;
    logic                  par_acc_r;
    logic                  err_r;

    logic                  rx_s;
    logic [PRESCALE_W-1:0] half_s;
    logic [PRESCALE_W-1:0] h_m1_s;
    logic [PRESCALE_W-1:0] h_p1_s;
    logic [PRESCALE_W-1:0] h_p2_s;
    logic [PRESCALE_W-1:0] prescale_sel_s;
    logic                  last_edge_s;
    logic                  vote_s;
    logic                  par_bad_s;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic par_mismatch(input logic acc, input logic typ, input logic rx_bit);
        return rx_bit ^ acc ^ typ;
    endfunction

`ifdef RX_SYNC_EN
    logic [1:0] sync_r;

    // Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], RX_IN};
        end
    end

    assign rx_s = sync_r[1];
`else
    assign rx_s = RX_IN;
`endif

    // Sample-point arithmetic, vote of the two stored samples with the live third one, ratio legalisation.
    always_comb begin
        half_s      = prescale_r >> 1;
        h_m1_s      = half_s - PRESCALE_W'(1);
        h_p1_s      = half_s + PRESCALE_W'(1);
        h_p2_s      = half_s + PRESCALE_W'(2);
        last_edge_s = (edge_cnt_r == (prescale_r - PRESCALE_W'(1)));
        vote_s      = maj3(samp0_r, samp1_r, rx_s);
        par_bad_s   = par_mismatch(par_acc_r, PAR_TYP, vote_s);
        if ((Prescale == PRESCALE_W'(16)) || (Prescale == PRESCALE_W'(32))) begin
            prescale_sel_s = Prescale;
        end else begin
            prescale_sel_s = PRESCALE_W'(8);
        end
    end

    // Frame FSM with sampling, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            prescale_r  <= PRESCALE_W'(8);
            edge_cnt_r  <= '0;
            bit_cnt_r   <= '0;
            samp0_r     <= 1'b0;
            samp1_r     <= 1'b0;
            par_acc_r   <= 1'b0;
            err_r       <= 1'b0;
            sampled_bit <= 1'b0;
            deser_en    <= 1'b0;
            new_op_flag <= 1'b0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            new_op_flag <= 1'b0;
            deser_en    <= 1'b0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;

            // Third sample is never stored: it is voted straight onto sampled_bit.
            if (state_r != IDLE) begin
                if (edge_cnt_r == h_m1_s) begin
                    samp0_r <= rx_s;
                end else if (edge_cnt_r == half_s) begin
                    samp1_r <= rx_s;
                end else if (edge_cnt_r == h_p1_s) begin
                    sampled_bit <= vote_s;
                end else begin
                    samp0_r <= samp0_r;
                end
            end

            case (state_r)
                IDLE: begin
                    prescale_r <= prescale_sel_s;
                    edge_cnt_r <= '0;
                    bit_cnt_r  <= '0;
                    if (!rx_s) begin
                        state_r     <= START;
                        edge_cnt_r  <= PRESCALE_W'(1);
                        new_op_flag <= 1'b1;
                        busy        <= 1'b1;
                        par_acc_r   <= 1'b0;
                        err_r       <= 1'b0;
                    end
                end
                START: begin
                    if ((edge_cnt_r == h_p2_s) && sampled_bit) begin
                        state_r    <= IDLE;
                        busy       <= 1'b0;
                        edge_cnt_r <= '0;
                    end else if (last_edge_s) begin
                        state_r    <= DATA;
                        edge_cnt_r <= '0;
                    end else begin
                        edge_cnt_r <= edge_cnt_r + PRESCALE_W'(1);
                    end
                end
                DATA: begin
                    if (edge_cnt_r == h_p1_s) begin
                        deser_en  <= 1'b1;
                        par_acc_r <= par_acc_r ^ vote_s;
                    end
                    if (last_edge_s) begin
                        edge_cnt_r <= '0;
                        if (bit_cnt_r == LAST_BIT) begin
                            bit_cnt_r <= '0;
                            state_r   <= PAR_EN ? PARITY : STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BCW'(1);
                        end
                    end else begin
                        edge_cnt_r <= edge_cnt_r + PRESCALE_W'(1);
                    end
                end
                PARITY: begin
                    if ((edge_cnt_r == h_p1_s) && par_bad_s) begin
                        par_err <= 1'b1;
                        err_r   <= 1'b1;
                    end
                    if (last_edge_s) begin
                        state_r    <= STOP;
                        edge_cnt_r <= '0;
                    end else begin
                        edge_cnt_r <= edge_cnt_r + PRESCALE_W'(1);
                    end
                end
                STOP: begin
                    // Leave at the vote so a start bit right after the stop bit is not missed.
                    if (edge_cnt_r == h_p1_s) begin
                        if (!vote_s) begin
                            stp_err <= 1'b1;
                        end else if (!err_r) begin
                            data_valid <= 1'b1;
                        end
                        state_r    <= IDLE;
                        busy       <= 1'b0;
                        edge_cnt_r <= '0;
                    end else begin
                        edge_cnt_r <= edge_cnt_r + PRESCALE_W'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    busy       <= 1'b0;
                    edge_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed vector table, reset-mid-frame sequence and
// randomized frames scored cycle by cycle against a frame-level reference model.

module tb_uart_rx_ctrl;

    localparam int DW   = 8;
    localparam int PW   = 6;
    localparam int MAXC = 512;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          rx       = 1'b1;
    logic          par_en   = 1'b0;
    logic          par_typ  = 1'b0;
    logic [PW-1:0] prescale = 6'd8;
    logic          sampled_bit, deser_en, new_op_flag, data_valid, par_err, stp_err, busy;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst(rst), .RX_IN(rx), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .Prescale(prescale), .sampled_bit(sampled_bit), .deser_en(deser_en),
        .new_op_flag(new_op_flag), .data_valid(data_valid), .par_err(par_err),
        .stp_err(stp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         p_in;
        bit         pen;
        bit         ptyp;
        logic [7:0] data;
        bit         par_bad;
        bit         stop_bit;
        int         glitch;
        bit         flip;
        int         exp_de;
        logic [7:0] exp_data;
        int         exp_dv;
        int         exp_pe;
        int         exp_se;
        int         exp_evt;
        int         exp_idle;
    } vec_t;

    vec_t     vecs[8];
    bit       line_q[MAXC];
    bit [6:0] exp_q[MAXC];   // {new_op, deser_en, bit@deser, data_valid, par_err, stp_err, busy}
    bit [6:0] obs_q[MAXC];
    int       p_tab[10] = '{8, 16, 32, 8, 16, 32, 5, 0, 63, 12};
    int       n_checks = 0;
    int       n_fail = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    function automatic int eff_p(input int p_in);
        return ((p_in == 16) || (p_in == 32)) ? p_in : 8;
    endfunction

    function automatic bit vote(input int n, input int p);
        int h;
        int s;
        h = p / 2;
        s = int'(line_q[n*p+h-1]) + int'(line_q[n*p+h]) + int'(line_q[n*p+h+1]);
        return s >= 2;
    endfunction

    // Line waveform for one frame; returns its length in cycles.
    function automatic int build_line(input int p, input bit pen, input bit ptyp, input logic [7:0] data,
                                      input bit par_bad, input bit stop_bit, input int glitch, input bit flip);
        bit bits[DW+3];
        int nb;
        int h;
        h = p / 2;
        for (int c = 0; c < MAXC; c++) line_q[c] = 1'b1;
        if (glitch > 0) begin
            for (int c = 0; c < 2*p; c++) line_q[c] = (c >= glitch);
            return 2*p;
        end
        bits[0] = 1'b0;
        for (int k = 0; k < DW; k++) bits[k+1] = data[k];
        nb = DW + 1;
        if (pen) begin
            bits[nb] = (^data) ^ ptyp ^ par_bad;
            nb++;
        end
        bits[nb] = stop_bit;
        nb++;
        for (int c = 0; c < nb*p; c++) begin
            line_q[c] = bits[c/p] ^ (flip && ((c % p) == h));
        end
        // A low stop bit releases the line at the vote, otherwise it would read as a new start.
        for (int c = (nb-1)*p + h + 2; c < nb*p; c++) line_q[c] = 1'b1;
        return nb*p;
    endfunction

    // Reference model: expected outputs per cycle derived from the frame rules and the line waveform.
    function automatic void build_expected(input int p, input bit pen, input bit ptyp);
        int h;
        int dec;
        int nb;
        bit acc;
        bit perr;
        bit v;
        for (int c = 0; c < MAXC; c++) exp_q[c] = 7'd0;
        h = p / 2;
        exp_q[1][6] = 1'b1;
        if (vote(0, p)) begin
            for (int c = 1; c <= h + 2; c++) exp_q[c][0] = 1'b1;
            return;
        end
        acc = 1'b0;
        for (int k = 0; k < DW; k++) begin
            v   = vote(k + 1, p);
            dec = (k + 1)*p + h + 2;
            exp_q[dec][5] = 1'b1;
            exp_q[dec][4] = v;
            acc ^= v;
        end
        nb   = DW + 1;
        perr = 1'b0;
        if (pen) begin
            v   = vote(nb, p);
            dec = nb*p + h + 2;
            if (v != (acc ^ ptyp)) begin
                exp_q[dec][2] = 1'b1;
                perr = 1'b1;
            end
            nb++;
        end
        v   = vote(nb, p);
        dec = nb*p + h + 2;
        if (!v) exp_q[dec][1] = 1'b1;
        else if (!perr) exp_q[dec][3] = 1'b1;
        for (int c = 1; c < dec; c++) exp_q[c][0] = 1'b1;
    endfunction

    task automatic drive_cycles(input int first, input int last, input int p_in, input bit scramble);
        for (int c = first; c <= last; c++) begin
            rx = line_q[c];
            if (c == 0) prescale = PW'(p_in);
            else if (scramble) prescale = PW'($urandom);
            @(negedge clk);
            obs_q[c] = {new_op_flag, deser_en, deser_en & sampled_bit, data_valid, par_err, stp_err, busy};
            @(posedge clk);
            #1;
        end
    endtask

    task automatic compare_cycles(input int first, input int last, input string tag);
        for (int c = first; c <= last; c++) begin
            check($sformatf("%s cycle %0d outputs", tag, c), int'(obs_q[c]), int'(exp_q[c]));
        end
    endtask

    task automatic run_frame(input int p_in, input bit pen, input bit ptyp, input int n, input string tag,
                             input bit scramble, output int de_cnt, output logic [7:0] data,
                             output int dv_cnt, output int pe_cnt, output int se_cnt,
                             output int evt, output int idle);
        int p;
        p = eff_p(p_in);
        par_en  = pen;
        par_typ = ptyp;
        build_expected(p, pen, ptyp);
        drive_cycles(0, n - 1, p_in, scramble);
        compare_cycles(0, n - 1, tag);
        de_cnt = 0; data = 8'h00; dv_cnt = 0; pe_cnt = 0; se_cnt = 0; evt = -1; idle = -1;
        for (int c = 0; c < n; c++) begin
            if (obs_q[c][5]) begin
                de_cnt++;
                data = {obs_q[c][4], data[7:1]};
            end
            dv_cnt += int'(obs_q[c][3]);
            pe_cnt += int'(obs_q[c][2]);
            se_cnt += int'(obs_q[c][1]);
            if ((evt < 0) && (obs_q[c][3] || obs_q[c][2] || obs_q[c][1])) evt = c;
            if ((idle < 0) && (c >= 1) && !obs_q[c][0]) idle = c;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n, de_cnt, dv_cnt, pe_cnt, se_cnt, evt, idle;
        logic [7:0] data;
        n = build_line(eff_p(v.p_in), v.pen, v.ptyp, v.data, v.par_bad, v.stop_bit, v.glitch, v.flip);
        run_frame(v.p_in, v.pen, v.ptyp, n, tag, 1'b0, de_cnt, data, dv_cnt, pe_cnt, se_cnt, evt, idle);
        check({tag, " deser_en pulses"}, de_cnt, v.exp_de);
        check({tag, " assembled data"}, int'(data), int'(v.exp_data));
        check({tag, " data_valid pulses"}, dv_cnt, v.exp_dv);
        check({tag, " par_err pulses"}, pe_cnt, v.exp_pe);
        check({tag, " stp_err pulses"}, se_cnt, v.exp_se);
        check({tag, " first result cycle"}, evt, v.exp_evt);
        check({tag, " busy low cycle"}, idle, v.exp_idle);
    endtask

    initial begin
        int n, p, h, nbits, de_cnt, dv_cnt, pe_cnt, se_cnt, evt, idle, glitch, p_in;
        bit pen, ptyp;
        logic [7:0] data, rdata;

        vecs[0] = '{8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 0, 1'b0, 8, 8'hA5, 1, 0, 0, 86,  86};
        vecs[1] = '{8,  1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 0, 1'b0, 8, 8'hA5, 0, 1, 0, 78,  86};
        vecs[2] = '{16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 0, 1'b0, 8, 8'h3C, 0, 0, 1, 154, 154};
        vecs[3] = '{8,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3, 1'b0, 0, 8'h00, 0, 0, 0, -1,  7};
        vecs[4] = '{8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 0, 1'b1, 8, 8'hA5, 1, 0, 0, 86,  86};
        vecs[5] = '{32, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8, 8'h00, 1, 0, 0, 338, 338};
        vecs[6] = '{5,  1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 0, 1'b0, 8, 8'hFF, 1, 0, 0, 78,  78};
        vecs[7] = '{16, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 0, 1'b0, 8, 8'h07, 0, 1, 1, 154, 170};

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs", int'({sampled_bit, deser_en, new_op_flag, data_valid, par_err, stp_err, busy}), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset pulse at cycle 40, in the middle of the data bits.
        par_en  = 1'b1;
        par_typ = 1'b0;
        n = build_line(8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 0, 1'b0);
        build_expected(8, 1'b1, 1'b0);
        drive_cycles(0, 39, 8, 1'b0);
        rx  = line_q[40];
        rst = 1'b0;
        @(negedge clk);
        obs_q[40] = {new_op_flag, deser_en, deser_en & sampled_bit, data_valid, par_err, stp_err, busy};
        @(posedge clk);
        #1;
        rst = 1'b1;
        compare_cycles(0, 40, "pre_reset");
        dv_cnt = 0;
        for (int c = 41; c <= 140; c++) begin
            rx = 1'b1;
            @(negedge clk);
            dv_cnt += int'(data_valid);
            check($sformatf("post_reset cycle %0d outputs", c),
                  int'({sampled_bit, deser_en, new_op_flag, data_valid, par_err, stp_err, busy}), 0);
            @(posedge clk);
            #1;
        end
        check("post_reset data_valid pulses", dv_cnt, 0);
        run_vec(vecs[0], "after_reset");

        // Randomized back-to-back frames with sample noise and Prescale changing mid-frame.
        for (int f = 0; f < 40; f++) begin
            p_in = p_tab[$urandom_range(0, 9)];
            p    = eff_p(p_in);
            h    = p / 2;
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                glitch = $urandom_range(1, h - 1);
                n = build_line(p, pen, ptyp, data, 1'b0, 1'b1, glitch, 1'b0);
            end else begin
                glitch = 0;
                n = build_line(p, pen, ptyp, data, ($urandom_range(0, 3) == 0),
                               ($urandom_range(0, 5) != 0), 0, 1'b0);
                nbits = n / p;
                for (int b = 0; b < nbits; b++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        line_q[b*p + h - 1 + $urandom_range(0, 2)] ^= 1'b1;
                    end
                end
                for (int c = 1; c < (nbits - 1)*p; c++) begin
                    if ((((c % p) < h - 1) || ((c % p) > h + 1)) && ($urandom_range(0, 15) == 0)) begin
                        line_q[c] ^= 1'b1;
                    end
                end
            end
            run_frame(p_in, pen, ptyp, n, $sformatf("rand%0d", f), 1'b1,
                      de_cnt, rdata, dv_cnt, pe_cnt, se_cnt, evt, idle);
            check($sformatf("rand%0d deser_en pulses", f), de_cnt, (glitch > 0) ? 0 : DW);
            check($sformatf("rand%0d assembled data", f), int'(rdata), (glitch > 0) ? 0 : int'(data));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
